sonar_ping_controller: RTL and testbench

- Sequences one ultrasonic ranging cycle per request: issues the trigger pulse, waits for the echo rising edge, times the echo high width in 1 us units, then enforces a hold-off before the next ping.
- Sits between the sensor pins and the distance consumer (display / host logic). It replaces the free-running trigger/echo handshake with one controller that owns trigger timing, timeouts and result validity.

---
 rtl/sonar_pkg.sv | 20 ++
 rtl/sonar_ping_controller_if.sv | 24 ++
 rtl/us_tick_gen.sv | 24 ++
 rtl/sonar_ping_controller.sv | 142 ++++++++++++++
 tb/tb_sonar_ping_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared state encoding and default timing for the ultrasonic ranging path.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    RESULT    = 3'd4,
    HOLDOFF   = 3'd5
  } sonar_state_e;

  localparam int unsigned DEF_CLK_PER_US   = 100;
  localparam int unsigned DEF_TRIG_US      = 10;
  localparam int unsigned DEF_ECHO_WAIT_US = 30000;
  localparam int unsigned DEF_MAX_ECHO_US  = 25000;
  localparam int unsigned DEF_HOLDOFF_US   = 60000;
  localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/sonar_ping_controller_if.sv
// Sensor pins and result signals of the ping controller; slave = controller side.
interface sonar_ping_controller_if import sonar_pkg::*; #(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             start;
  logic             continuous;
  logic             echo;
  logic             trigger;
  logic             busy;
  logic [CNT_W-1:0] distance;
  logic             valid;
  logic             no_echo;
  logic             out_of_range;

  modport master (
    output start, continuous, echo,
    input  trigger, busy, distance, valid, no_echo, out_of_range
  );

  modport slave (
    input  start, continuous, echo,
    output trigger, busy, distance, valid, no_echo, out_of_range
  );
endinterface

// File: rtl/us_tick_gen.sv
// Free-running prescaler: one-CLK tick strobe every CLK_PER_US cycles.
module us_tick_gen import sonar_pkg::*; #(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);
  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  assign tick = (pre_q == LAST);
endmodule

// File: rtl/sonar_ping_controller.sv
// One ranging cycle per request: trigger, wait for echo, time echo width in us, hold off.
module sonar_ping_controller import sonar_pkg::*; #(
  parameter int unsigned CLK_PER_US   = DEF_CLK_PER_US,
  parameter int unsigned TRIG_US      = DEF_TRIG_US,
  parameter int unsigned ECHO_WAIT_US = DEF_ECHO_WAIT_US,
  parameter int unsigned MAX_ECHO_US  = DEF_MAX_ECHO_US,
  parameter int unsigned HOLDOFF_US   = DEF_HOLDOFF_US,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  sonar_ping_controller_if.slave  bus
);
  localparam logic [CNT_W-1:0] TRIG_LIM = CNT_W'(TRIG_US);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(ECHO_WAIT_US);
  localparam logic [CNT_W-1:0] MAX_LIM  = CNT_W'(MAX_ECHO_US);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLDOFF_US);

  logic tick;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .tick  (tick)
  );

  logic echo_s1_q, echo_s1_d;
  logic echo_s2_q, echo_s2_d;
  logic echo_s3_q, echo_s3_d;
  logic echo_rise, echo_fall;

  sonar_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dist_q, dist_d;
  logic             no_echo_q, no_echo_d;
  logic             oor_q, oor_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  always_comb begin
    echo_s1_d = bus.echo;
    echo_s2_d = echo_s1_q;
    echo_s3_d = echo_s2_q;
  end

  assign echo_rise = echo_s2_q & ~echo_s3_q;
  assign echo_fall = ~echo_s2_q & echo_s3_q;

  always_comb begin
    state_d   = state_q;
    dist_d    = dist_q;
    no_echo_d = no_echo_q;
    oor_d     = oor_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = TRIG;
      end
      TRIG: begin
        if (cnt_q >= TRIG_LIM) state_d = WAIT_ECHO;
      end
      WAIT_ECHO: begin
        // Rise is checked first so a rise coinciding with timeout still measures.
        if (echo_rise) begin
          state_d = MEASURE;
        end else if (cnt_q >= WAIT_LIM) begin
          state_d   = RESULT;
          dist_d    = '0;
          no_echo_d = 1'b1;
          oor_d     = 1'b0;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_d   = RESULT;
          dist_d    = cnt_q;
          no_echo_d = 1'b0;
          oor_d     = 1'b0;
        end else if (cnt_q >= MAX_LIM) begin
          state_d   = RESULT;
          dist_d    = MAX_LIM;
          no_echo_d = 1'b0;
          oor_d     = 1'b1;
        end
      end
      RESULT: begin
        state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (cnt_q >= HOLD_LIM) state_d = bus.continuous ? TRIG : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q)             cnt_d = '0;
    else if (tick && (cnt_q != '1))     cnt_d = cnt_q + 1'b1;
    else                                cnt_d = cnt_q;

    // Outputs are registered from the next state so they switch with the state flop.
    trig_d  = (state_d == TRIG);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == RESULT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      dist_q    <= '0;
      no_echo_q <= 1'b0;
      oor_q     <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      echo_s1_q <= echo_s1_d;
      echo_s2_q <= echo_s2_d;
      echo_s3_q <= echo_s3_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dist_q    <= dist_d;
      no_echo_q <= no_echo_d;
      oor_q     <= oor_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.trigger      = trig_q;
  assign bus.busy         = busy_q;
  assign bus.distance     = dist_q;
  assign bus.valid        = valid_q;
  assign bus.no_echo      = no_echo_q;
  assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_sonar_ping_controller.sv
// Directed bench for sonar_ping_controller with scaled-down timing parameters.
module tb_sonar_ping_controller;
  localparam int unsigned P     = 4;
  localparam int unsigned TRIG  = 10;
  localparam int unsigned WAIT  = 250;
  localparam int unsigned MAXE  = 600;
  localparam int unsigned HOLD  = 400;
  localparam int unsigned W     = 16;

  localparam int SEL_TRIG  = 0;
  localparam int SEL_VALID = 1;
  localparam int SEL_BUSY  = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sonar_ping_controller_if #(.CNT_W(W)) bus ();

  sonar_ping_controller #(
    .CLK_PER_US   (P),
    .TRIG_US      (TRIG),
    .ECHO_WAIT_US (WAIT),
    .MAX_ECHO_US  (MAXE),
    .HOLDOFF_US   (HOLD),
    .CNT_W        (W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int trig_rises = 0;
  int valid_cnt = 0;
  logic trig_prev = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (bus.trigger === 1'b1 && trig_prev !== 1'b1) trig_rises++;
    trig_prev = bus.trigger;
    if (bus.valid === 1'b1) valid_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      SEL_TRIG:  return bus.trigger;
      SEL_VALID: return bus.valid;
      default:   return bus.busy;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int max_cyc,
                          output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max_cyc) begin
      @(negedge CLK);
      n++;
      if (sel_sig(sel) === lvl) ok = 1'b1;
    end
  endtask

  task automatic ping_start(output bit ok, output int n);
    @(negedge CLK);
    bus.start = 1'b1;
    wait_for(SEL_TRIG, 1'b1, 8, ok, n);
    bus.start = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    int w;
    int tv, tt;
    int stamp [3];

    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.echo = 1'b0;
    RST_N = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_distance", bus.distance, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_no_echo", bus.no_echo, 0);
    chk("rst_oor", bus.out_of_range, 0);
    RST_N = 1'b1;

    // Single ping, 580 us echo after 200 us
    ping_start(ok, n);
    chk("t1_trig_seen", ok, 1);
    chk("t1_trig_latency", n, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t1_trig_fall", ok, 1);
    chk_rng("t1_trig_width", n, (TRIG-1)*P + 1, TRIG*P + 2);
    chk("t1_busy", bus.busy, 1);
    repeat (200*P) @(negedge CLK);
    bus.echo = 1'b1;
    repeat (580*P) @(negedge CLK);
    bus.echo = 1'b0;
    wait_for(SEL_VALID, 1'b1, 20, ok, n);
    chk("t1_valid_seen", ok, 1);
    chk("t1_valid_latency", n, 3);
    chk_rng("t1_distance", bus.distance, 579, 580);
    chk("t1_no_echo", bus.no_echo, 0);
    chk("t1_oor", bus.out_of_range, 0);
    @(negedge CLK);
    chk("t1_valid_one_clk", bus.valid, 0);
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t1_busy_drop", ok, 1);
    chk_rng("t1_holdoff", n, (HOLD-1)*P, HOLD*P + 4);
    chk_rng("t1_distance_hold", bus.distance, 579, 580);
    chk("t1_valid_count", valid_cnt, 1);
    chk("t1_trig_count", trig_rises, 1);

    // No echo: timeout
    ping_start(ok, n);
    chk("t2_trig_seen", ok, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t2_trig_fall", ok, 1);
    wait_for(SEL_VALID, 1'b1, WAIT*P + 20, ok, n);
    chk("t2_valid_seen", ok, 1);
    chk_rng("t2_timeout", n, (WAIT-1)*P, WAIT*P + 4);
    chk("t2_no_echo", bus.no_echo, 1);
    chk("t2_distance", bus.distance, 0);
    chk("t2_oor", bus.out_of_range, 0);
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t2_busy_drop", ok, 1);
    chk("t2_no_echo_hold", bus.no_echo, 1);
    chk("t2_valid_count", valid_cnt, 2);

    // Echo stuck high: saturation, then stale echo in holdoff
    ping_start(ok, n);
    chk("t3_trig_seen", ok, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t3_trig_fall", ok, 1);
    repeat (200*P) @(negedge CLK);
    bus.echo = 1'b1;
    wait_for(SEL_VALID, 1'b1, MAXE*P + 40, ok, n);
    chk("t3_valid_seen", ok, 1);
    chk_rng("t3_sat_time", n, (MAXE-1)*P, MAXE*P + 8);
    chk("t3_distance", bus.distance, MAXE);
    chk("t3_oor", bus.out_of_range, 1);
    chk("t3_no_echo", bus.no_echo, 0);
    repeat (100*P) @(negedge CLK);
    bus.echo = 1'b0;
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t3_busy_drop", ok, 1);
    chk("t3_valid_count", valid_cnt, 3);
    chk("t3_trig_count", trig_rises, 3);

    // Continuous mode, widths 100/200/300, stop after third ping
    bus.continuous = 1'b1;
    ping_start(ok, n);
    chk("t4_trig_seen", ok, 1);
    for (int i = 0; i < 3; i++) begin
      w = 100 * (i + 1);
      if (i > 0) begin
        wait_for(SEL_TRIG, 1'b1, HOLD*P + 20, ok, n);
        chk("t4_retrigger", ok, 1);
      end
      wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
      chk("t4_trig_fall", ok, 1);
      repeat (50*P) @(negedge CLK);
      bus.echo = 1'b1;
      if (i == 2) bus.continuous = 1'b0;
      repeat (w*P) @(negedge CLK);
      bus.echo = 1'b0;
      wait_for(SEL_VALID, 1'b1, 20, ok, n);
      chk("t4_valid_seen", ok, 1);
      stamp[i] = cyc;
      chk_rng("t4_distance", bus.distance, w - 1, w);
      if (i > 0)
        chk_rng("t4_spacing", stamp[i] - stamp[i-1],
                (HOLD + TRIG + 50 + w)*P - P, (HOLD + TRIG + 50 + w)*P + 2*P);
    end
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t4_busy_drop", ok, 1);
    repeat (20*P) @(negedge CLK);
    chk("t4_trig_count", trig_rises, 6);
    chk("t4_valid_count", valid_cnt, 6);
    chk("t4_idle", bus.busy, 0);

    // Asynchronous reset during MEASURE, then a normal ping
    ping_start(ok, n);
    chk("t5_trig_seen", ok, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t5_trig_fall", ok, 1);
    repeat (20*P) @(negedge CLK);
    bus.echo = 1'b1;
    repeat (50*P) @(negedge CLK);
    chk("t5_busy_before", bus.busy, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_rst_trigger", bus.trigger, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_valid", bus.valid, 0);
    chk("t5_rst_distance", bus.distance, 0);
    @(negedge CLK);
    bus.echo = 1'b0;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    ping_start(ok, n);
    chk("t5_ping_seen", ok, 1);
    chk("t5_ping_latency", n, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t5_ping_fall", ok, 1);
    repeat (30*P) @(negedge CLK);
    bus.echo = 1'b1;
    repeat (150*P) @(negedge CLK);
    bus.echo = 1'b0;
    wait_for(SEL_VALID, 1'b1, 20, ok, n);
    chk("t5_valid_latency", n, 3);
    chk_rng("t5_distance", bus.distance, 149, 150);
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t5_busy_drop", ok, 1);

    // start toggled while busy
    repeat (4) @(negedge CLK);
    tv = valid_cnt;
    tt = trig_rises;
    ping_start(ok, n);
    chk("t6_trig_seen", ok, 1);
    wait_for(SEL_TRIG, 1'b0, TRIG*P + 8, ok, n);
    chk("t6_trig_fall", ok, 1);
    repeat (30*P) @(negedge CLK);
    bus.echo = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      bus.start = ~bus.start;
    end
    bus.start = 1'b0;
    repeat (120*P - 40) @(negedge CLK);
    bus.echo = 1'b0;
    wait_for(SEL_VALID, 1'b1, 20, ok, n);
    chk("t6_valid_seen", ok, 1);
    chk_rng("t6_distance", bus.distance, 119, 120);
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      bus.start = ~bus.start;
    end
    bus.start = 1'b0;
    wait_for(SEL_BUSY, 1'b0, HOLD*P + 20, ok, n);
    chk("t6_busy_drop", ok, 1);
    repeat (10) @(negedge CLK);
    chk("t6_trig_count", trig_rises, tt + 1);
    chk("t6_valid_count", valid_cnt, tv + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
